uart_tx_fifo: RTL

- Byte FIFO plus drain controller sitting directly upstream of the UART transmit path.
- Write side: CPU/MMIO bus pushes bytes with a single-cycle write strobe.
- Read side: pops one byte at a time and issues a one-cycle launch pulse with data to the transmitter, honouring its busy flag.
- Decouples bursty software writes from the slow serial bit rate.

---
 rtl/uart_tx_fifo.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with a drain controller feeding a UART transmitter.
// Software pushes bytes at bus speed. The controller pops one byte at a time and
// issues a single launch pulse per byte. It then waits for the transmitter to show
// busy and go idle again before it pops the next byte.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            wr_data_i,
  input  logic                  wr_en_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_en_o,
  input  logic                  tx_busy_i
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DepthCnt = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   CntOne   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

  state_e                 state_q;
  logic [7:0]             mem_q [Depth];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic                   overflow_q;
  logic                   tx_en_q;
  logic [7:0]             tx_data_q;

  logic full, empty, wr_accept, pop;

  assign full      = (count_q == DepthCnt);
  assign empty     = (count_q == '0);
  // Full is judged on the registered count, so a pop in the same cycle does not
  // open a slot for a simultaneous write.
  assign wr_accept = wr_en_i && !full;
  assign pop       = (state_q == StIdle) && !empty && !tx_busy_i;

  // Occupancy next-state: net of accepted write and pop.
  always_comb begin
    count_d = count_q;
    if (wr_accept && !pop) begin
      count_d = count_q + CntOne;
    end else if (!wr_accept && pop) begin
      count_d = count_q - CntOne;
    end
  end

  // Storage array, no reset: contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, count, sticky overflow and the drain FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      state_q    <= StIdle;
    end else begin
      count_q <= count_d;
      tx_en_q <= 1'b0;
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (wr_en_i && full) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tx_data_q <= mem_q[rd_ptr_q];
            rd_ptr_q  <= rd_ptr_q + PtrOne;
            tx_en_q   <= 1'b1;
            state_q   <= StLaunch;
          end
        end
        StLaunch: state_q <= StWaitBusy;
        // Wait for the transmitter to acknowledge the launch before watching for idle.
        StWaitBusy: begin
          if (tx_busy_i) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (!tx_busy_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign tx_en_o    = tx_en_q;
  assign tx_data_o  = tx_data_q;

endmodule
